// File: rtl/dragonfang_floating_point_pkg.sv
// Shared single-precision types plus the conversion-arbiter FSM encoding.
package dragonfang_floating_point_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_t;

  localparam float_t ZERO_FLOAT = '0;
  localparam logic [7:0] FLOAT_BIAS = 8'd127;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_RESPOND = 2'd2
  } arb_state_e;

endpackage

// File: rtl/longint_to_shortreal_converter.sv
// Combinational 64-bit integer to single-precision conversion, mantissa truncated.
module longint_to_shortreal_converter
  import dragonfang_floating_point_pkg::*;
(
  input  logic [63:0] int_value,
  input  logic        sign_mode,
  output float_t      float_value
);

  logic        negative;
  logic [63:0] magnitude;
  logic [5:0]  lead;

  always_comb begin
    negative  = sign_mode & int_value[63];
    magnitude = negative ? (~int_value + 64'd1) : int_value;
    lead      = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (magnitude[i]) lead = 6'(i);
    end
    float_value.sign     = negative;
    float_value.exponent = FLOAT_BIAS + {2'b00, lead};
    // The 23 bits just below the leading one land at [22:0]; lower bits are dropped.
    float_value.mantissa = 23'({magnitude[62:0], 23'b0} >> lead);
  end

endmodule

// File: rtl/int_to_float_conversion_arbiter.sv
// Round-robin arbiter feeding a single shared integer-to-float converter.
module int_to_float_conversion_arbiter
  import dragonfang_floating_point_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  input  logic [NUM_REQUESTERS-1:0][63:0]      req_integer,
  input  logic [NUM_REQUESTERS-1:0]            req_sign_mode,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output float_t                               rsp_float,
  output logic [$clog2(NUM_REQUESTERS)-1:0]    rsp_requester_id,
  output logic                                 busy
);

  localparam int unsigned ID_W = $clog2(NUM_REQUESTERS);

  arb_state_e  state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [63:0] op_value_q, op_value_d;
  logic        op_sign_q, op_sign_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  float_t      rsp_float_q, rsp_float_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        busy_q, busy_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            handshake;
  float_t          conv_float;

  longint_to_shortreal_converter u_converter (
    .int_value   (op_value_q),
    .sign_mode   (op_sign_q),
    .float_value (conv_float)
  );

  // Scan from the pointer upward, wrapping; the first valid requester wins.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQUESTERS;
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && state_q == ST_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign handshake = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_value_d  = op_value_q;
    op_sign_d   = op_sign_q;
    op_id_d     = op_id_q;
    rsp_float_d = rsp_float_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          op_value_d = req_integer[grant_idx];
          op_sign_d  = req_sign_mode[grant_idx];
          op_id_d    = grant_idx;
          ptr_d      = (grant_idx == ID_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
          state_d    = ST_CONVERT;
          busy_d     = 1'b1;
        end
      end
      ST_CONVERT: begin
        rsp_float_d = (op_value_q == '0) ? ZERO_FLOAT : conv_float;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      op_value_q  <= '0;
      op_sign_q   <= 1'b0;
      op_id_q     <= '0;
      rsp_float_q <= ZERO_FLOAT;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_value_q  <= op_value_d;
      op_sign_q   <= op_sign_d;
      op_id_q     <= op_id_d;
      rsp_float_q <= rsp_float_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid        = rsp_valid_q;
  assign rsp_float        = rsp_float_q;
  assign rsp_requester_id = rsp_id_q;
  assign busy             = busy_q;

endmodule
